// File: rtl/wb_io_pad_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// wb_io_pad_ctrl_pkg
// Shared definitions for the Wishbone pad controller: register byte offsets,
// register reset values, the Wishbone address-window mask and a helper that
// decodes a byte offset into a register selector.
// Optional feature macro: WB_IO_PAD_CTRL_FALL_EDGE_EN (IRQ_EDGE register).
// -----------------------------------------------------------------------------
package wb_io_pad_ctrl_pkg;

  localparam logic [7:0] OFS_OWNER    = 8'h00;
  localparam logic [7:0] OFS_OUT      = 8'h04;
  localparam logic [7:0] OFS_OEB      = 8'h08;
  localparam logic [7:0] OFS_IN       = 8'h0C;
  localparam logic [7:0] OFS_IRQ_EN   = 8'h10;
  localparam logic [7:0] OFS_IRQ_PEND = 8'h14;
  localparam logic [7:0] OFS_IRQ_EDGE = 8'h18;

  // Only adr[31:8] takes part in the window match; adr[7:0] is the offset.
  localparam logic [31:0] ADDR_WIN_MASK = 32'hFFFF_FF00;

  // Reset values are kept at the maximum pad count and sliced by the user.
  localparam int                 MAX_PADS     = 8;
  localparam logic [MAX_PADS-1:0] RST_OWNER    = '0;
  localparam logic [MAX_PADS-1:0] RST_OUT      = '0;
  localparam logic [MAX_PADS-1:0] RST_OEB      = '1;
  localparam logic [MAX_PADS-1:0] RST_IRQ_EN   = '0;
  localparam logic [MAX_PADS-1:0] RST_IRQ_PEND = '0;
  localparam logic [MAX_PADS-1:0] RST_IRQ_EDGE = '0;

  typedef enum logic [2:0] {
    REG_OWNER,
    REG_OUT,
    REG_OEB,
    REG_IN,
    REG_IRQ_EN,
    REG_IRQ_PEND,
    REG_IRQ_EDGE,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_reg(input logic [7:0] ofs);
    reg_sel_e sel;
    case (ofs)
      OFS_OWNER:    sel = REG_OWNER;
      OFS_OUT:      sel = REG_OUT;
      OFS_OEB:      sel = REG_OEB;
      OFS_IN:       sel = REG_IN;
      OFS_IRQ_EN:   sel = REG_IRQ_EN;
      OFS_IRQ_PEND: sel = REG_IRQ_PEND;
      OFS_IRQ_EDGE: sel = REG_IRQ_EDGE;
      default:      sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/wb_io_pad_ctrl_if.sv
// -----------------------------------------------------------------------------
// wb_io_pad_ctrl_if
// Wishbone classic slave bundle for wb_io_pad_ctrl. Signal names keep the
// caravel user-wrapper spelling so the wiring stays obvious.
//   wbs_stb_i, wbs_cyc_i, wbs_we_i : strobe, cycle, write enable
//   wbs_sel_i[3:0]                 : byte selects (only bit 0 matters here)
//   wbs_dat_i[31:0], wbs_adr_i     : write data, byte address
//   wbs_ack_o, wbs_dat_o[31:0]     : acknowledge, read data
// Modports: master (bus side), slave (controller side).
// -----------------------------------------------------------------------------
interface wb_io_pad_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_io_pad_ctrl_io_sync_edge.sv
// -----------------------------------------------------------------------------
// io_sync_edge
// Per-bit two-flop synchronizer followed by a previous-value flop, giving a
// synchronized level plus single-cycle rise and fall pulses.
//   clk_i, rst_i : clock, synchronous active-high reset (all flops to 0)
//   d_i[W-1:0]   : asynchronous pad inputs
//   sync_o       : second synchronizer stage (2-cycle latency)
//   rise_o       : sync & !prev
//   fall_o       : !sync & prev
// -----------------------------------------------------------------------------
module io_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;

  // NOTE: non-blocking assignments make each stage take its neighbour's
  // pre-edge value; blocking ones would collapse the chain into one flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/wb_io_pad_ctrl.sv
// -----------------------------------------------------------------------------
// wb_io_pad_ctrl
// Wishbone slave that owns the upper user GPIO pads. Per pad, firmware
// registers or the user core drive pad_out/pad_oeb; pad inputs are
// synchronized, edge-detected and turned into a maskable sticky interrupt.
// Optional feature macro: WB_IO_PAD_CTRL_FALL_EDGE_EN adds IRQ_EDGE at 0x18
// selecting falling-edge detection per pad; without it 0x18 reads 0.
//   wb_clk_i, wb_rst_i      : clock, synchronous active-high reset
//   wb (slave modport)      : Wishbone port, single-cycle ack latency
//   core_io_out/core_io_oeb : user-core pad drive
//   core_io_in              : synchronized pad inputs to the user core
//   pad_in/pad_out/pad_oeb  : pad bus
//   irq                     : |(IRQ_PEND & IRQ_EN), registered
// -----------------------------------------------------------------------------
module wb_io_pad_ctrl
  import wb_io_pad_ctrl_pkg::*;
#(
  parameter int          NPADS     = 5,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wb_io_pad_ctrl_if.slave  wb,
  input  logic [NPADS-1:0] core_io_out,
  input  logic [NPADS-1:0] core_io_oeb,
  output logic [NPADS-1:0] core_io_in,
  input  logic [NPADS-1:0] pad_in,
  output logic [NPADS-1:0] pad_out,
  output logic [NPADS-1:0] pad_oeb,
  output logic             irq
);

  // Bus handshake and the latched request that commits in the ack cycle.
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  reg_sel_e         acc_reg_q, acc_reg_d;
  logic             wr_q, wr_d;
  logic [NPADS-1:0] wdat_q, wdat_d;

  // Programmer-visible registers.
  logic [NPADS-1:0] owner_q, owner_d;
  logic [NPADS-1:0] out_q, out_d;
  logic [NPADS-1:0] oeb_q, oeb_d;
  logic [NPADS-1:0] en_q, en_d;
  logic [NPADS-1:0] pend_q, pend_d;
  logic             irq_q, irq_d;
`ifdef WB_IO_PAD_CTRL_FALL_EDGE_EN
  logic [NPADS-1:0] edge_q, edge_d;
`endif

  logic             addr_hit;
  logic             req;
  reg_sel_e         acc_reg;
  logic [31:0]      rd_data;
  logic [NPADS-1:0] w1c;
  logic [NPADS-1:0] in_sync, in_rise, in_fall, edge_hit;

  assign addr_hit = ((wb.wbs_adr_i ^ BASE_ADDR) & ADDR_WIN_MASK) == 32'h0;
  // Refusing a request during its own ack cycle spaces a held strobe to one
  // ack every two cycles.
  assign req      = wb.wbs_stb_i & wb.wbs_cyc_i & addr_hit & ~ack_q;
  assign acc_reg  = decode_reg({wb.wbs_adr_i[7:2], 2'b00});

  io_sync_edge #(.W(NPADS)) u_sync (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .d_i    (pad_in),
    .sync_o (in_sync),
    .rise_o (in_rise),
    .fall_o (in_fall)
  );

`ifdef WB_IO_PAD_CTRL_FALL_EDGE_EN
  assign edge_hit = (edge_q & in_fall) | (~edge_q & in_rise);
  logic unused_ok;
  assign unused_ok = &{1'b0, wb.wbs_sel_i[3:1], wb.wbs_dat_i[31:NPADS]};
`else
  assign edge_hit = in_rise;
  logic unused_ok;
  assign unused_ok = &{1'b0, wb.wbs_sel_i[3:1], wb.wbs_dat_i[31:NPADS], in_fall};
`endif

  // Read data is sampled at the request edge so it is stable through ack.
  always_comb begin
    rd_data = '0;
    case (acc_reg)
      REG_OWNER:    rd_data = 32'(owner_q);
      REG_OUT:      rd_data = 32'(out_q);
      REG_OEB:      rd_data = 32'(oeb_q);
      REG_IN:       rd_data = 32'(in_sync);
      REG_IRQ_EN:   rd_data = 32'(en_q);
      REG_IRQ_PEND: rd_data = 32'(pend_q);
`ifdef WB_IO_PAD_CTRL_FALL_EDGE_EN
      REG_IRQ_EDGE: rd_data = 32'(edge_q);
`endif
      default:      rd_data = '0;
    endcase
  end

  // NOTE: every signal gets a default first so no branch can infer a latch.
  always_comb begin
    ack_d     = req;
    dat_d     = '0;
    acc_reg_d = acc_reg_q;
    wr_d      = wr_q;
    wdat_d    = wdat_q;
    owner_d   = owner_q;
    out_d     = out_q;
    oeb_d     = oeb_q;
    en_d      = en_q;
    w1c       = '0;
`ifdef WB_IO_PAD_CTRL_FALL_EDGE_EN
    edge_d    = edge_q;
`endif

    if (req) begin
      acc_reg_d = acc_reg;
      wr_d      = wb.wbs_we_i & wb.wbs_sel_i[0];
      wdat_d    = wb.wbs_dat_i[NPADS-1:0];
      if (!wb.wbs_we_i) dat_d = rd_data;
    end

    // Writes land at the end of the ack cycle; IN and unmapped offsets drop.
    if (ack_q && wr_q) begin
      case (acc_reg_q)
        REG_OWNER:    owner_d = wdat_q;
        REG_OUT:      out_d   = wdat_q;
        REG_OEB:      oeb_d   = wdat_q;
        REG_IRQ_EN:   en_d    = wdat_q;
        REG_IRQ_PEND: w1c     = wdat_q;
`ifdef WB_IO_PAD_CTRL_FALL_EDGE_EN
        REG_IRQ_EDGE: edge_d  = wdat_q;
`endif
        default:      ;
      endcase
    end

    // A new edge outranks a simultaneous write-1-to-clear.
    pend_d = (pend_q & ~w1c) | edge_hit;
    irq_d  = |(pend_q & en_q);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      acc_reg_q <= REG_NONE;
      wr_q      <= 1'b0;
      wdat_q    <= '0;
      owner_q   <= RST_OWNER[NPADS-1:0];
      out_q     <= RST_OUT[NPADS-1:0];
      oeb_q     <= RST_OEB[NPADS-1:0];
      en_q      <= RST_IRQ_EN[NPADS-1:0];
      pend_q    <= RST_IRQ_PEND[NPADS-1:0];
      irq_q     <= 1'b0;
`ifdef WB_IO_PAD_CTRL_FALL_EDGE_EN
      edge_q    <= RST_IRQ_EDGE[NPADS-1:0];
`endif
    end else begin
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      acc_reg_q <= acc_reg_d;
      wr_q      <= wr_d;
      wdat_q    <= wdat_d;
      owner_q   <= owner_d;
      out_q     <= out_d;
      oeb_q     <= oeb_d;
      en_q      <= en_d;
      pend_q    <= pend_d;
      irq_q     <= irq_d;
`ifdef WB_IO_PAD_CTRL_FALL_EDGE_EN
      edge_q    <= edge_d;
`endif
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;

  assign pad_out    = (owner_q & out_q) | (~owner_q & core_io_out);
  assign pad_oeb    = (owner_q & oeb_q) | (~owner_q & core_io_oeb);
  assign core_io_in = in_sync;
  assign irq        = irq_q;

endmodule

// File: tb/tb_wb_io_pad_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_io_pad_ctrl
// Directed bench for wb_io_pad_ctrl. A register-array model predicts every
// output each cycle; literal expectations pin the model at key points.
// Define WB_IO_PAD_CTRL_FALL_EDGE_EN to exercise the IRQ_EDGE register.
// -----------------------------------------------------------------------------
module tb_wb_io_pad_ctrl;

  localparam int NP = 5;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] A_OWN  = BASE + 32'h00;
  localparam logic [31:0] A_OUT  = BASE + 32'h04;
  localparam logic [31:0] A_OEB  = BASE + 32'h08;
  localparam logic [31:0] A_EN   = BASE + 32'h10;
  localparam logic [31:0] A_PEND = BASE + 32'h14;
  localparam logic [31:0] A_EDGE = BASE + 32'h18;
`ifdef WB_IO_PAD_CTRL_FALL_EDGE_EN
  localparam bit FALL_EN = 1'b1;
`else
  localparam bit FALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_io_pad_ctrl_if wb();
  logic [NP-1:0] core_io_out, core_io_oeb, core_io_in;
  logic [NP-1:0] pad_in, pad_out, pad_oeb;
  logic          irq;

  wb_io_pad_ctrl #(.NPADS(NP), .BASE_ADDR(BASE)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wb          (wb),
    .core_io_out (core_io_out),
    .core_io_oeb (core_io_oeb),
    .core_io_in  (core_io_in),
    .pad_in      (pad_in),
    .pad_out     (pad_out),
    .pad_oeb     (pad_oeb),
    .irq         (irq)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: registers live in an array indexed by word offset; the pad input
  // history is a three-deep array of samples taken at each clock edge.
  // ---------------------------------------------------------------------------
  logic [NP-1:0] m_reg [64];
  logic [NP-1:0] m_pin [3];
  logic          m_on = 1'b0;
  logic          m_ack, m_irq, m_wr;
  logic [31:0]   m_dat;
  logic [5:0]    m_wr_idx;
  logic [NP-1:0] m_wr_val;

  function automatic bit mapped(input logic [5:0] idx);
    return idx <= (FALL_EN ? 6'd6 : 6'd5);
  endfunction

  always @(posedge clk) begin : model
    logic [NP-1:0] sync, prev, hit, pend;
    logic [5:0]    idx;
    logic          req;
    if (rst) begin
      foreach (m_reg[i]) m_reg[i] = '0;
      m_reg[2] = '1;
      foreach (m_pin[i]) m_pin[i] = '0;
      m_ack = 1'b0; m_dat = '0; m_irq = 1'b0; m_wr = 1'b0; m_on = 1'b1;
    end else begin
      sync = m_pin[1];
      prev = m_pin[2];
      hit  = sync & ~prev;
      if (FALL_EN) hit = (m_reg[6] & ~sync & prev) | (~m_reg[6] & sync & ~prev);
      m_irq = |(m_reg[5] & m_reg[4]);
      req = wb.wbs_stb_i && wb.wbs_cyc_i && (wb.wbs_adr_i[31:8] == BASE[31:8]) && !m_ack;
      idx = wb.wbs_adr_i[7:2];
      m_dat = '0;
      if (req && !wb.wbs_we_i && mapped(idx)) m_dat = 32'((idx == 6'd3) ? sync : m_reg[idx]);
      pend = m_reg[5];
      if (m_ack && m_wr && mapped(m_wr_idx)) begin
        if (m_wr_idx == 6'd5)      pend = pend & ~m_wr_val;
        else if (m_wr_idx != 6'd3) m_reg[m_wr_idx] = m_wr_val;
      end
      m_reg[5] = pend | hit;
      if (req) begin
        m_wr     = wb.wbs_we_i && wb.wbs_sel_i[0];
        m_wr_idx = idx;
        m_wr_val = wb.wbs_dat_i[NP-1:0];
      end
      m_ack = req;
      m_pin[2] = m_pin[1];
      m_pin[1] = m_pin[0];
      m_pin[0] = pad_in;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_on) begin
      check("cyc_ack",     32'(wb.wbs_ack_o), 32'(m_ack));
      check("cyc_dat",     wb.wbs_dat_o, m_dat);
      check("cyc_pad_out", 32'(pad_out), 32'((m_reg[0] & m_reg[1]) | (~m_reg[0] & core_io_out)));
      check("cyc_pad_oeb", 32'(pad_oeb), 32'((m_reg[0] & m_reg[2]) | (~m_reg[0] & core_io_oeb)));
      check("cyc_core_in", 32'(core_io_in), 32'(m_pin[1]));
      check("cyc_irq",     32'(irq), 32'(m_irq));
    end
  end

  // ---------------------------------------------------------------------------
  // Bus tasks: drive just after a rising edge, wait a bounded number of edges
  // for ack, then idle one extra cycle so the next access starts clean.
  // ---------------------------------------------------------------------------
  task automatic bus_idle();
    wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
    wb.wbs_sel_i = 4'h0; wb.wbs_dat_i = '0;   wb.wbs_adr_i = '0;
  endtask

  task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic [31:0] rdat, output int lat);
    wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = we;
    wb.wbs_sel_i = sel;  wb.wbs_dat_i = wdat; wb.wbs_adr_i = adr;
    lat = -1; rdat = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o) begin
        lat = c; rdat = wb.wbs_dat_o;
        break;
      end
    end
    bus_idle();
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat, input logic [3:0] sel);
    logic [31:0] d; int lat;
    wb_access(adr, 1'b1, wdat, sel, d, lat);
    check("wr_latency", 32'(lat), 32'd1);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat, output int lat);
    wb_access(adr, 1'b0, '0, 4'hF, rdat, lat);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] rd;
    int          lat;
    int          acks;

    bus_idle();
    pad_in = '0; core_io_out = '0; core_io_oeb = '1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state: pads are inputs, nothing driven, no ack, no irq.
    check("rst_pad_oeb", 32'(pad_oeb), 32'h1F);
    check("rst_pad_out", 32'(pad_out), 32'h00);
    check("rst_ack",     32'(wb.wbs_ack_o), 32'h0);
    check("rst_irq",     32'(irq), 32'h0);
    wb_read(A_OEB, rd, lat);
    check("rd_oeb_val", rd, 32'h1F);
    check("rd_oeb_lat", 32'(lat), 32'd1);

    // Core ownership, then hand every pad to firmware.
    core_io_out = 5'b10101; core_io_oeb = '0;
    @(posedge clk); #1;
    check("core_pad_out", 32'(pad_out), 32'h15);
    wb_write(A_OWN, 32'h1F, 4'hF);
    wb_write(A_OUT, 32'h0A, 4'hF);
    wb_write(A_OEB, 32'h00, 4'hF);
    check("fw_pad_out", 32'(pad_out), 32'h0A);
    check("fw_pad_oeb", 32'(pad_oeb), 32'h00);

    // Rising edge on pad 0: sync after 2 edges, PEND after 3, irq after 4.
    wb_write(A_EN, 32'h01, 4'hF);
    pad_in[0] = 1'b1;
    @(posedge clk); #1;
    check("sync_1cyc", 32'(core_io_in[0]), 32'h0);
    @(posedge clk); #1;
    check("sync_2cyc", 32'(core_io_in[0]), 32'h1);
    @(posedge clk); #1;
    check("irq_3cyc", 32'(irq), 32'h0);
    @(posedge clk); #1;
    check("irq_4cyc", 32'(irq), 32'h1);
    wb_read(A_PEND, rd, lat);
    check("pend_set", rd, 32'h01);

    // Write-1-to-clear drops irq one cycle after the commit.
    wb_write(A_PEND, 32'h01, 4'hF);
    @(posedge clk); #1;
    check("irq_cleared", 32'(irq), 32'h0);

    // New rising edge lands in the same cycle as the W1C commit: set wins.
    pad_in[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 pad_in[0] = 1'b1;
    @(posedge clk); #1;
    wb_write(A_PEND, 32'h01, 4'hF);
    wb_read(A_PEND, rd, lat);
    check("pend_set_wins", rd, 32'h01);

    // Unmapped offsets inside the window are acked and read 0.
    wb_read(BASE + 32'h20, rd, lat);
    check("unmapped_val", rd, 32'h0);
    check("unmapped_lat", 32'(lat), 32'd1);
`ifndef WB_IO_PAD_CTRL_FALL_EDGE_EN
    wb_read(A_EDGE, rd, lat);
    check("edge_ofs_unmapped", rd, 32'h0);
`endif

    // Outside the window: never acked.
    wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_sel_i = 4'hF;
    wb.wbs_adr_i = 32'h3000_0100;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o) acks++;
    end
    bus_idle();
    @(posedge clk); #1;
    check("foreign_noack", 32'(acks), 32'd0);

    // sel[0]=0 write is acked but leaves OUT untouched.
    wb_write(A_OUT, 32'h15, 4'h0);
    wb_read(A_OUT, rd, lat);
    check("sel0_ignored", rd, 32'h0A);

    // Held strobe for 6 edges: acks on edges 1, 3, 5.
    wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_sel_i = 4'hF;
    wb.wbs_adr_i = A_OEB;
    acks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o) acks++;
    end
    bus_idle();
    @(posedge clk); #1;
    check("held_stb_acks", 32'(acks), 32'd3);

    // Request raised together with reset: aborted, no ack, registers reset.
    wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = 1'b1;
    wb.wbs_sel_i = 4'hF; wb.wbs_dat_i = 32'h1F; wb.wbs_adr_i = A_OUT;
    rst = 1'b1;
    acks = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o) acks++;
    end
    check("rst_abort_noack", 32'(acks), 32'd0);
    bus_idle();
    rst = 1'b0;
    wb_read(A_OUT, rd, lat);
    check("rst_out", rd, 32'h0);
    wb_read(A_OWN, rd, lat);
    check("rst_owner", rd, 32'h0);
    // Pad 0 was held high through reset: one edge after release sets PEND.
    wb_read(A_PEND, rd, lat);
    check("held_high_edge", rd, 32'h01);
    check("held_high_noirq", 32'(irq), 32'h0);

`ifdef WB_IO_PAD_CTRL_FALL_EDGE_EN
    // Pad 1 configured for falling edges: the rise is ignored, the fall fires.
    wb_write(A_PEND, 32'h1F, 4'hF);
    wb_write(A_EDGE, 32'h02, 4'hF);
    wb_write(A_EN,   32'h02, 4'hF);
    pad_in[1] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("fall_rise_noirq", 32'(irq), 32'h0);
    wb_read(A_PEND, rd, lat);
    check("fall_rise_nopend", rd, 32'h00);
    pad_in[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("fall_irq", 32'(irq), 32'h1);
    wb_read(A_EDGE, rd, lat);
    check("edge_readback", rd, 32'h02);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
